// File: rtl/wb_arb_pkg.sv
// ============================================================================
// Module   : wb_arb_pkg
// Purpose  : Shared types and constants for the Wishbone round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_arb_pkg;

  // Arbiter FSM states. ABORT is reachable only when the watchdog is built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  // Outstanding-transaction counter width and its saturation value.
  localparam int                 OUTST_W   = 4;
  localparam logic [OUTST_W-1:0] OUTST_MAX = 4'd15;

endpackage

`default_nettype wire

// File: rtl/rr_prio_enc.sv
// ============================================================================
// Module   : rr_prio_enc
// Purpose  : Round-robin priority encoder. Searches the request vector
//            starting one position after last_grant (wrapping) and returns
//            the first requester as a one-hot grant plus a valid flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_prio_enc #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  // Rotating search: offset 1..N from last_grant, first hit wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx   = '0;
    gnt   = '0;
    valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % N);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
// ============================================================================
// Module   : wb_rr_arbiter
// Purpose  : Round-robin arbiter placing NUM_MASTERS pipelined Wishbone
//            masters onto one slave. Ownership lasts while the owner holds
//            m_cyc; a 4-bit counter tracks outstanding requests and stalls
//            the owner at saturation.
// Options  : define WB_ARB_TIMEOUT_EN to build the slave-response watchdog
//            (TIMEOUT_CYC cycles without a response -> ABORT with m_err).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ADR_W       = 30,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // master side
  input  logic [NUM_MASTERS-1:0]       m_cyc,
  input  logic [NUM_MASTERS-1:0]       m_stb,
  input  logic [NUM_MASTERS-1:0]       m_we,
  input  logic [NUM_MASTERS*ADR_W-1:0] m_adr,
  input  logic [NUM_MASTERS*32-1:0]    m_dat_w,
  input  logic [NUM_MASTERS*4-1:0]     m_sel,
  output logic [NUM_MASTERS-1:0]       m_stall,
  output logic [NUM_MASTERS-1:0]       m_ack,
  output logic [NUM_MASTERS-1:0]       m_err,
  output logic [31:0]                  m_dat_r,
  // slave side
  output logic                         s_cyc,
  output logic                         s_stb,
  output logic                         s_we,
  output logic [ADR_W-1:0]             s_adr,
  output logic [31:0]                  s_dat_w,
  output logic [3:0]                   s_sel,
  input  logic                         s_stall,
  input  logic                         s_ack,
  input  logic                         s_err,
  input  logic [31:0]                  s_dat_r,
  // status
  output logic [NUM_MASTERS-1:0]       grant,
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  // Reject unsupported configurations at elaboration time.
  generate
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || ADR_W < 1 || TIMEOUT_CYC < 2) begin : g_bad_param
      $error("wb_rr_arbiter: parameter out of supported range");
    end
  endgenerate

  arb_state_t             state;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       last_grant;
  logic [OUTST_W-1:0]     outstanding;
  logic [OUTST_W-1:0]     outst_next;

  logic [NUM_MASTERS-1:0] pick;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;

  logic                   owned;
  logic                   sat;
  logic                   accept;
  logic                   resp;

  logic                   own_cyc;
  logic                   own_stb;
  logic                   own_we;
  logic [ADR_W-1:0]       own_adr;
  logic [31:0]            own_dat;
  logic [3:0]             own_sel;

  rr_prio_enc #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_prio_enc (
    .req        (m_cyc),
    .last_grant (last_grant),
    .gnt        (pick),
    .valid      (pick_valid)
  );

  // Binary index of the chosen requester, stored as the owner.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  // Owner's request signals.
  assign own_cyc = m_cyc[owner];
  assign own_stb = m_stb[owner];
  assign own_we  = m_we[owner];
  assign own_adr = m_adr[int'(owner)*ADR_W +: ADR_W];
  assign own_dat = m_dat_w[int'(owner)*32 +: 32];
  assign own_sel = m_sel[int'(owner)*4 +: 4];

  assign owned = (state == OWNED);
  assign sat   = (outstanding == OUTST_MAX);

  // Slave bus follows the owner; s_cyc drops the moment the owner lets go,
  // and the strobe is withheld at saturation so the count can never wrap.
  assign s_cyc   = owned & own_cyc;
  assign s_stb   = s_cyc & own_stb & ~sat;
  assign s_we    = s_cyc & own_we;
  assign s_adr   = s_cyc ? own_adr : '0;
  assign s_dat_w = s_cyc ? own_dat : '0;
  assign s_sel   = s_cyc ? own_sel : '0;

  assign accept  = s_stb & ~s_stall;
  assign resp    = s_cyc & (s_ack | s_err);

  assign m_dat_r = s_dat_r;

  // Route stall/ack/err to the owner only; everyone else sees a stalled bus.
  always_comb begin
    m_stall = '1;
    m_ack   = '0;
    m_err   = '0;
    if (s_cyc) begin
      m_stall[owner] = s_stall | sat;
      m_ack[owner]   = s_ack;
      m_err[owner]   = s_err;
    end
`ifdef WB_ARB_TIMEOUT_EN
    if (state == ABORT) m_err[owner] = 1'b1;
`endif
  end

  // Next outstanding count; simultaneous request and response cancel out.
  always_comb begin
    outst_next = outstanding;
    if (accept && !resp && !sat) begin
      outst_next = outstanding + OUTST_W'(1);
    end else if (resp && !accept && outstanding != '0) begin
      outst_next = outstanding - OUTST_W'(1);
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd;
  logic [WD_W-1:0] wd_next;
  logic            wd_hit;

  // Watchdog advances only while waiting on a response; any response resets it.
  always_comb begin
    wd_next = '0;
    wd_hit  = 1'b0;
    if (outstanding != '0 && !resp) begin
      wd_next = wd + WD_W'(1);
      wd_hit  = (wd == WD_W'(TIMEOUT_CYC - 1));
    end
  end
`endif

  // Arbitration FSM with registered grant/busy and bookkeeping state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      busy        <= 1'b0;
      owner       <= '0;
      last_grant  <= IDX_W'(NUM_MASTERS - 1);
      outstanding <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      wd          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state <= OWNED;
            grant <= pick;
            busy  <= 1'b1;
            owner <= pick_idx;
          end
        end
        OWNED: begin
          if (!own_cyc) begin
            state       <= IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            last_grant  <= owner;
            outstanding <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            wd          <= '0;
`endif
          end
`ifdef WB_ARB_TIMEOUT_EN
          else if (wd_hit) begin
            state       <= ABORT;
            outstanding <= '0;
            wd          <= '0;
          end
`endif
          else begin
            outstanding <= outst_next;
`ifdef WB_ARB_TIMEOUT_EN
            wd          <= wd_next;
`endif
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        ABORT: begin
          state      <= IDLE;
          grant      <= '0;
          busy       <= 1'b0;
          last_grant <= owner;
        end
`endif
        default: begin
          state       <= IDLE;
          grant       <= '0;
          busy        <= 1'b0;
          outstanding <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 3, number of requesting Wishbone masters (2..8).
REQ-002 SHALL have parameter ADR_W, default 30, word-address width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, the slave-response watchdog limit in cycles.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, named as in the codebase.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
REQ-005 SHALL have these master-side ports (N = NUM_MASTERS):
- m_cyc, m_stb, m_we  in  N each  per-master cycle, strobe, write
- m_adr  in  N*ADR_W  per-master address
- m_dat_w  in  N*32  per-master write data
- m_sel  in  N*4  per-master byte selects
- m_stall, m_ack, m_err  out  N each  per-master stall, ack, err
- m_dat_r  out  32  read data, broadcast to all masters
REQ-006 SHALL have these slave-side ports:
- s_cyc, s_stb, s_we  out  1 each
- s_adr  out  ADR_W
- s_dat_w  out  32
- s_sel  out  4
- s_stall, s_ack, s_err  in  1 each
- s_dat_r  in  32
REQ-007 SHALL have these status ports:
- grant  out  N  one-hot current owner, 0 when idle
- busy  out  1  bus owned

Function
REQ-008 SHALL implement FSM states IDLE, OWNED and ABORT.
REQ-009 In IDLE, SHALL pick the requester (m_cyc=1) first in round-robin order starting at last_grant+1 mod N, and register it into grant; the state becomes OWNED on the next edge (1-cycle grant latency).
REQ-010 In IDLE, SHALL drive all m_stall=1 and all m_ack/m_err=0, with s_cyc=s_stb=0.
REQ-011 In OWNED, SHALL drive s_cyc, s_stb, s_we, s_adr, s_dat_w and s_sel combinationally from the granted master.
REQ-012 In OWNED, the granted master's m_ack=s_ack and m_err=s_err, and non-granted masters SHALL see m_stall=1 and m_ack=m_err=0.
REQ-013 SHALL keep a 4-bit outstanding counter: +1 on s_stb&!s_stall, -1 on s_ack|s_err, with both events on one edge leaving it unchanged.
REQ-014 SHALL assert the granted m_stall whenever s_stall=1 or outstanding=15 (saturation; no wrap).
REQ-015 When the granted m_cyc=0 in OWNED, SHALL go to IDLE next edge, update last_grant, clear outstanding and drop s_cyc combinationally; late s_ack is ignored.
REQ-016 Ownership SHALL NOT be preempted while the owner holds m_cyc.
REQ-017 A master dropping and reasserting m_cyc SHALL re-arbitrate, and other requesters take priority per round-robin.

Reset
REQ-018 On rst_n=0, asynchronously: state=IDLE, grant=0, busy=0, outstanding=0, last_grant=N-1 (master 0 wins first), all m_ack/m_err=0, all m_stall=1, and all s_* outputs 0.
REQ-019 Reset mid-transfer SHALL abandon the cycle without emitting ack or err.

Configuration
REQ-020 With WB_ARB_TIMEOUT_EN defined, a watchdog SHALL count OWNED cycles with outstanding>0 and no s_ack/s_err, clearing on any response.
- At TIMEOUT_CYC: enter ABORT, pulse granted m_err for 1 cycle, force s_cyc=0, clear outstanding.
- ABORT then goes to IDLE, with last_grant updated.
REQ-021 Without WB_ARB_TIMEOUT_EN, there SHALL be no watchdog or ABORT state, and a hung slave holds the bus indefinitely.

Structure
REQ-022 Package wb_arb_pkg SHALL hold the state enum, OUTST_W=4 and OUTST_MAX=15.
REQ-023 The round-robin selection SHALL be sub-module rr_prio_enc (inputs: req vector and last_grant index; outputs: one-hot grant and valid).

Verification
REQ-024 Reset release with m_cyc=3'b111 -> grant=3'b001 one cycle later; then successive cyc drops -> grants 010, 100, 001.
REQ-025 Master1 issues 4 pipelined reads, slave acks with 2-cycle delay -> m_ack[1] 4 pulses, m_dat_r matches, m_ack[0]/[2]=0.
REQ-026 Master0 issues 16 strobes with acks held off -> m_stall[0]=1 after the 15th accepted strobe, and outstanding never exceeds 15.
REQ-027 Master2 owns the bus while master0 requests -> grant stays 100 until m_cyc[2] drops, then becomes 001.
REQ-028 WB_ARB_TIMEOUT_EN with TIMEOUT_CYC=16 and the slave never acking -> m_err single pulse 16 cycles after the stall-free strobe, s_cyc=0, then IDLE.
REQ-029 rst_n pulsed low mid-burst -> all outputs at reset values in the same cycle, and no stray m_ack afterward.
